// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback path.
package rf_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t        rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot grant; the search starts just after the
// last granted index and the pointer moves only when something is granted.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr;
   logic [PW-1:0] win_idx;
   logic          found;

   // Visit candidates in rotation order ptr+1, ptr+2, ... and take the first requester.
   always_comb begin
      gnt     = '0;
      win_idx = ptr;
      found   = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
               gnt[i]  = 1'b1;
               win_idx = PW'(i);
               found   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= PW'(N - 1);
      end else if (found) begin
         ptr <= win_idx;
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler: round-robin onto the single register-file write port,
// plus a pending-write scoreboard that exists only when RF_SCOREBOARD_EN is defined.
module rf_wb_scheduler #(
   parameter int NUM_SRC    = 2,
   parameter int XLEN       = rf_pkg::XLEN,
   parameter int REG_ADDR_W = rf_pkg::REG_ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd,
   input  logic [NUM_SRC*XLEN-1:0]       src_data,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic                          rf_w_en,
   output logic [REG_ADDR_W-1:0]         rf_rd,
   output logic [XLEN-1:0]               rf_rdv,
   input  logic                          iss_valid,
   input  logic [REG_ADDR_W-1:0]         iss_rd,
   input  logic [REG_ADDR_W-1:0]         chk_rs1,
   input  logic [REG_ADDR_W-1:0]         chk_rs2,
   input  logic [REG_ADDR_W-1:0]         chk_rd,
   output logic                          hazard,
   output logic [31:0]                   busy_mask
);

   import rf_pkg::*;

   logic [NUM_SRC-1:0]    req;
   logic [NUM_SRC-1:0]    gnt;
   logic                  any_gnt;
   logic [REG_ADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;

   // Requests are masked during reset so nothing is granted while rst_n is low.
   assign req       = src_valid & {NUM_SRC{rst_n}};
   assign src_ready = gnt;
   assign any_gnt   = |gnt;

   rr_arbiter #(.N(NUM_SRC)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .gnt   (gnt)
   );

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gnt[i]) begin
            sel_rd   = src_rd[i*REG_ADDR_W +: REG_ADDR_W];
            sel_data = src_data[i*XLEN +: XLEN];
         end
      end
   end

   // A grant to x0 is consumed and loads the stage, but never raises the write enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_w_en <= 1'b0;
         rf_rd   <= '0;
         rf_rdv  <= '0;
      end else begin
         rf_w_en <= any_gnt && (sel_rd != '0);
         if (any_gnt) begin
            rf_rd  <= sel_rd;
            rf_rdv <= sel_data;
         end
      end
   end

`ifdef RF_SCOREBOARD_EN
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic                rs1_hit;
   logic                rs2_hit;
   logic                rd_hit;

   // The set is applied after the clear so a newer producer keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      if (rf_w_en) begin
         busy_nxt[rf_rd] = 1'b0;
      end
      if (iss_valid) begin
         busy_nxt[iss_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Sources being written this cycle are forwarded by the register file; the destination is not.
   assign rs1_hit   = (chk_rs1 != '0) && busy[chk_rs1] && !(rf_w_en && (rf_rd == chk_rs1));
   assign rs2_hit   = (chk_rs2 != '0) && busy[chk_rs2] && !(rf_w_en && (rf_rd == chk_rs2));
   assign rd_hit    = (chk_rd  != '0) && busy[chk_rd];
   assign hazard    = rs1_hit || rs2_hit || rd_hit;
   assign busy_mask = busy;
`else
   logic unused_sb;

   assign unused_sb = ^{iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd};
   assign hazard    = 1'b0;
   assign busy_mask = '0;
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_rf_wb_scheduler;

   localparam int NS = 2;
   localparam int AW = 5;
   localparam int DW = 32;
`ifdef RF_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic [NS-1:0]     src_valid;
   logic [NS*AW-1:0]  src_rd;
   logic [NS*DW-1:0]  src_data;
   logic [NS-1:0]     src_ready;
   logic              rf_w_en;
   logic [AW-1:0]     rf_rd;
   logic [DW-1:0]     rf_rdv;
   logic              iss_valid;
   logic [AW-1:0]     iss_rd;
   logic [AW-1:0]     chk_rs1;
   logic [AW-1:0]     chk_rs2;
   logic [AW-1:0]     chk_rd;
   logic              hazard;
   logic [31:0]       busy_mask;

   int nChecks = 0;
   int nFails  = 0;

   // Behavioural model: what the port and scoreboard must show right now.
   int          m_ptr;
   bit          m_wen;
   logic [4:0]  m_rd;
   logic [31:0] m_rdv;
   bit          m_rdKnown;
   logic [31:0] m_busy;
   int          lastGrant;

   rf_wb_scheduler #(.NUM_SRC(NS), .XLEN(DW), .REG_ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_valid (src_valid),
      .src_rd    (src_rd),
      .src_data  (src_data),
      .src_ready (src_ready),
      .rf_w_en   (rf_w_en),
      .rf_rd     (rf_rd),
      .rf_rdv    (rf_rdv),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .chk_rs1   (chk_rs1),
      .chk_rs2   (chk_rs2),
      .chk_rd    (chk_rd),
      .hazard    (hazard),
      .busy_mask (busy_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int modelGrant();
      if (!rst_n) return -1;
      for (int k = 1; k <= NS; k++) begin
         int idx;
         idx = (m_ptr + k) % NS;
         if (src_valid[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic bit isPending(input logic [4:0] r);
      return SB_EN && (r != 5'd0) && m_busy[r];
   endfunction

   function automatic bit modelHazard();
      bit onPort1, onPort2;
      onPort1 = m_wen && (m_rd == chk_rs1);
      onPort2 = m_wen && (m_rd == chk_rs2);
      return (isPending(chk_rs1) && !onPort1) || (isPending(chk_rs2) && !onPort2) || isPending(chk_rd);
   endfunction

   function automatic void modelReset();
      m_ptr     = NS - 1;
      m_wen     = 1'b0;
      m_rd      = '0;
      m_rdv     = '0;
      m_rdKnown = 1'b1;
      m_busy    = '0;
   endfunction

   // Let inputs settle, then compare every observable output with the model.
   task automatic evalCycle();
      int g;
      logic [NS-1:0] expReady;
      #1;
      g = modelGrant();
      expReady = '0;
      if (g >= 0) expReady[g] = 1'b1;
      checkOutput("src_ready", 64'(src_ready), 64'(expReady));
      checkOutput("rf_w_en", 64'(rf_w_en), 64'(m_wen));
      if (m_rdKnown) begin
         checkOutput("rf_rd", 64'(rf_rd), 64'(m_rd));
         checkOutput("rf_rdv", 64'(rf_rdv), 64'(m_rdv));
      end
      checkOutput("busy_mask", 64'(busy_mask), 64'(m_busy));
      checkOutput("hazard", 64'(hazard), 64'(modelHazard()));
   endtask

   // Advance the model across the next rising edge, then move to the falling edge.
   task automatic applyStimulus();
      int g;
      logic [31:0] nb;
      logic [4:0]  grd;
      g = modelGrant();
      lastGrant = g;
      if (rst_n) begin
         nb = m_busy;
         if (SB_EN) begin
            if (m_wen) nb[m_rd] = 1'b0;
            if (iss_valid && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
         end
         m_busy = nb;
         if (g >= 0) begin
            grd       = src_rd[g*AW +: AW];
            m_ptr     = g;
            m_rd      = grd;
            m_rdv     = src_data[g*DW +: DW];
            m_wen     = (grd != 5'd0);
            m_rdKnown = (grd != 5'd0);
         end else begin
            m_wen = 1'b0;
         end
      end
      @(negedge clk);
      if (g >= 0) src_valid[g] = 1'b0;
   endtask

   task automatic setSrc(input int i, input logic [4:0] rd, input logic [31:0] data);
      src_valid[i]         = 1'b1;
      src_rd[i*AW +: AW]   = rd;
      src_data[i*DW +: DW] = data;
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      modelReset();
      src_valid = '0;
      iss_valid = 1'b0;
      evalCycle();
      applyStimulus();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      src_valid = '0;
      src_rd    = '0;
      src_data  = '0;
      iss_valid = 1'b0;
      iss_rd    = '0;
      chk_rs1   = '0;
      chk_rs2   = '0;
      chk_rd    = '0;
      lastGrant = -1;
      modelReset();

      // Reset held with src0 requesting, then its first write.
      setSrc(0, 5'd5, 32'hA5A5_0001);
      @(negedge clk);
      evalCycle();
      checkOutput("reset src_ready", 64'(src_ready), 64'h0);
      checkOutput("reset rf_w_en", 64'(rf_w_en), 64'h0);
      checkOutput("reset rf_rdv", 64'(rf_rdv), 64'h0);
      checkOutput("reset busy_mask", 64'(busy_mask), 64'h0);
      applyStimulus();
      rst_n = 1'b1;
      evalCycle();
      checkOutput("first grant", 64'(src_ready), 64'h1);
      applyStimulus();
      evalCycle();
      checkOutput("first w_en", 64'(rf_w_en), 64'h1);
      checkOutput("first rd", 64'(rf_rd), 64'd5);
      checkOutput("first rdv", 64'(rf_rdv), 64'hA5A5_0001);
      applyStimulus();

      // Continuous contention alternates grants starting from source 0.
      doReset();
      for (int c = 0; c < 4; c++) begin
         setSrc(0, 5'd1, 32'h1000_0000 + 32'(c));
         setSrc(1, 5'd2, 32'h2000_0000 + 32'(c));
         evalCycle();
         checkOutput("alternate grant", 64'(src_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
         if (c > 0) checkOutput("alternate rd", 64'(rf_rd), (c % 2 == 0) ? 64'd2 : 64'd1);
         applyStimulus();
      end
      src_valid = '0;
      evalCycle();
      checkOutput("alternate last rd", 64'(rf_rd), 64'd2);
      checkOutput("alternate last rdv", 64'(rf_rdv), 64'h2000_0003);
      applyStimulus();

      // A write to x0 is consumed without enabling the port.
      setSrc(0, 5'd0, 32'hFFFF_FFFF);
      evalCycle();
      checkOutput("x0 grant", 64'(src_ready), 64'h1);
      applyStimulus();
      evalCycle();
      checkOutput("x0 w_en", 64'(rf_w_en), 64'h0);
      checkOutput("x0 busy", 64'(busy_mask), 64'h0);
      applyStimulus();

      // RAW on x7, cleared by its writeback with forwarding on the write cycle.
      iss_valid = 1'b1; iss_rd = 5'd7;
      evalCycle();
      applyStimulus();
      iss_valid = 1'b0; chk_rs1 = 5'd7;
      evalCycle();
      checkOutput("raw x7 hazard", 64'(hazard), 64'(SB_EN));
      checkOutput("raw x7 busy", 64'(busy_mask), SB_EN ? 64'h80 : 64'h0);
      applyStimulus();
      setSrc(0, 5'd7, 32'h0000_0077);
      evalCycle();
      checkOutput("x7 grant", 64'(src_ready), 64'h1);
      applyStimulus();
      evalCycle();
      checkOutput("x7 write w_en", 64'(rf_w_en), 64'h1);
      checkOutput("x7 forward hazard", 64'(hazard), 64'h0);
      applyStimulus();
      evalCycle();
      checkOutput("x7 cleared", 64'(busy_mask), 64'h0);
      chk_rs1 = 5'd0;
      applyStimulus();

      // Reissue of x9 on the edge its older write clears: set wins, chk_rd not forwarded.
      iss_valid = 1'b1; iss_rd = 5'd9;
      evalCycle();
      applyStimulus();
      iss_valid = 1'b0;
      setSrc(0, 5'd9, 32'h0000_0099);
      evalCycle();
      applyStimulus();
      iss_valid = 1'b1; iss_rd = 5'd9; chk_rd = 5'd9;
      evalCycle();
      checkOutput("x9 write w_en", 64'(rf_w_en), 64'h1);
      checkOutput("x9 waw hazard", 64'(hazard), 64'(SB_EN));
      applyStimulus();
      iss_valid = 1'b0;
      evalCycle();
      checkOutput("x9 stays busy", 64'(busy_mask), SB_EN ? 64'h200 : 64'h0);
      checkOutput("x9 rd hazard", 64'(hazard), 64'(SB_EN));
      chk_rd = 5'd0;
      applyStimulus();

      // Issue x3 and check it as rs1; both outputs are tied off when the scoreboard is absent.
      iss_valid = 1'b1; iss_rd = 5'd3;
      evalCycle();
      applyStimulus();
      iss_valid = 1'b0; chk_rs1 = 5'd3;
      evalCycle();
      checkOutput("x3 hazard", 64'(hazard), 64'(SB_EN));
      checkOutput("x3 busy", 64'(busy_mask), SB_EN ? 64'h208 : 64'h0);
      chk_rs1 = 5'd0;
      applyStimulus();

      // Randomized traffic with small register indices so hazards collide often.
      doReset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) doReset();
         for (int i = 0; i < NS; i++) begin
            if (!src_valid[i] && $urandom_range(0, 1) == 1)
               setSrc(i, 5'($urandom_range(0, 15)), $urandom);
         end
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_rd    = 5'($urandom_range(0, 15));
         chk_rs1   = 5'($urandom_range(0, 15));
         chk_rs2   = 5'($urandom_range(0, 15));
         chk_rd    = 5'($urandom_range(0, 15));
         evalCycle();
         applyStimulus();
      end

      $display("[TB] random phase done, last grant %0d", lastGrant);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Writeback scheduler for the 32x32 register file. It arbitrates up to NUM_SRC writeback producers (ALU, load unit, multiply/divide) onto the register file's single write port and drives `w_en`, `rd` and `rdv` from a registered output stage. It also keeps a pending-write scoreboard that the decode stage uses to stall on RAW and WAW hazards. It sits between the execute/memory units and the register file.

## Interface
Parameters:
- `NUM_SRC`, default 2: number of writeback requesters; legal range 2..4.
- `XLEN`, default 32: data width.
- `REG_ADDR_W`, default 5: register index width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `src_valid` in NUM_SRC: per-source write request.
- `src_rd` in NUM_SRC x REG_ADDR_W: per-source destination register.
- `src_data` in NUM_SRC x XLEN: per-source write data.
- `src_ready` out NUM_SRC: per-source grant. Combinational and one-hot or zero.
- `rf_w_en` out 1: register file write enable. Registered.
- `rf_rd` out REG_ADDR_W: register file destination. Registered.
- `rf_rdv` out XLEN: register file write data. Registered.
- `iss_valid` in 1: an instruction with a register destination issues this cycle.
- `iss_rd` in REG_ADDR_W: destination of the issuing instruction.
- `chk_rs1` in REG_ADDR_W: decode-stage source 1 to check.
- `chk_rs2` in REG_ADDR_W: decode-stage source 2 to check.
- `chk_rd` in REG_ADDR_W: decode-stage destination to check.
- `hazard` out 1: decode must stall. Combinational.
- `busy_mask` out 32: pending-write bit per register. Registered.

## Operation
Handshake and grant:
- A transfer occurs on `src_valid[i] && src_ready[i]`.
- A source holds its valid, rd and data stable until it is granted. It never drops valid before the grant.
- The register file never stalls, so a grant is issued in every cycle in which any source is valid.

Arbitration:
- Round-robin. A pointer holds the last granted index.
- Search order starts at the pointer + 1 and wraps modulo NUM_SRC.
- The pointer updates only on a grant.

Output stage:
- A granted request loads the output stage on the next edge: `rf_w_en`=1, `rf_rd`=`src_rd`, `rf_rdv`=`src_data`.
- With no grant, `rf_w_en`=0. `rf_rd` and `rf_rdv` hold their previous values.
- A granted request with rd==0 is consumed but loads `rf_w_en`=0.

Scoreboard:
- Set: `busy[iss_rd]` is set on an edge where `iss_valid` is high and `iss_rd`≠0.
- Clear: `busy[rf_rd]` is cleared on an edge where `rf_w_en` is high.
- When a set and a clear hit the same register on the same edge, set wins (a newer producer is in flight).
- `busy[0]` is always 0.
- `hazard` is asserted when any of `chk_rs1`, `chk_rs2` or `chk_rd` is nonzero and busy. A register whose write is currently on the port (`rf_w_en` and `rf_rd` match) is not a hazard for `chk_rs1` or `chk_rs2`, because the register file forwards `rdv`. That exemption does not apply to `chk_rd`.

Reset:
- All outputs go to 0. The pointer goes to NUM_SRC-1, so source 0 wins first.
- `src_ready` is 0 while `rst_n` is low.
- Reset mid-transfer drops the in-flight write. Pending busy bits are cleared, and the pipeline must be flushed with the reset.

## Timing
- Grant to `rf_w_en` is 1 cycle. The register file commits at the end of that cycle.
- Throughput is one write per cycle.
- A source wait is bounded by NUM_SRC-1 cycles under continuous contention.
- `src_ready` and `hazard` are combinational from their inputs and the current state. There are no combinational paths from `src_*` to `rf_*`.
- `busy_mask` reflects sets and clears one edge after they occur.

## Configuration
- `RF_SCOREBOARD_EN` defined: the scoreboard is present as described above.
- `RF_SCOREBOARD_EN` undefined:
  - The `iss_*` and `chk_*` ports remain in the interface but are ignored.
  - `busy_mask` ties to 0 and `hazard` ties to 0.
  - Hazard handling moves to the pipeline. Arbitration and the output stage are unchanged.

## Structure
- Shared package `rf_pkg` holds:
  - the constants XLEN, REG_ADDR_W and NUM_REGS=32;
  - the typedef `wb_req_t` {rd, data};
  - the typedef `reg_idx_t`.
- Sub-module `rr_arbiter` (parameter N) takes req[N] and produces a one-hot gnt[N]. It owns the pointer and updates it on any grant.
- The top level holds the output stage and the scoreboard.

## Test plan
- Reset with src0 valid: `src_ready`=0 and all outputs are 0. After release, src0 {rd=5, 0xA5A5_0001} is granted, and the next cycle shows `rf_w_en`=1, `rf_rd`=5, `rf_rdv`=0xA5A5_0001.
- Both sources valid for 4 cycles (rd=1 and rd=2): grants alternate 0,1,0,1, and the writes appear on the port one cycle later in the same order.
- Source request with rd=0 and data 0xFFFF_FFFF: it is granted, `rf_w_en` stays 0, and `busy_mask` is unchanged.
- Issue rd=7 then check `chk_rs1`=7: `hazard`=1. A writeback of rd=7 is granted, and in the cycle `rf_w_en` is high `hazard` reads 0. After that edge `busy_mask[7]`=0.
- Issue rd=9 on the same edge that writeback clears rd=9: `busy_mask[9]` stays 1. With `chk_rd`=9, `hazard`=1.
- Build without `RF_SCOREBOARD_EN`: issue rd=3 and check rs1=3. `hazard`=0 and `busy_mask`=0.
